// File: rtl/rename_alloc_if.sv
// Rename-group / freelist / branch-resolution bundle for rename_alloc_ctrl.
// slave = allocation controller, master = surrounding pipeline (decode, freelist, branch unit).
interface rename_alloc_if #(
   parameter int NUM_PREGS              = 64,
   parameter int MAX_PREDICT_DEPTH_BITS = 3
);
   localparam int NFW = $clog2(NUM_PREGS) + 1;

   logic                              req_valid;
   logic [1:0]                        req_count;
   logic [1:0]                        req_is_branch;
   logic                              req_ready;
   logic [NFW-1:0]                    num_free;
   logic [1:0]                        num_pull;
   logic [MAX_PREDICT_DEPTH_BITS-1:0] branch_tag_1;
   logic [MAX_PREDICT_DEPTH_BITS-1:0] branch_tag_2;
   logic [MAX_PREDICT_DEPTH_BITS-1:0] new_tag_1;
   logic [MAX_PREDICT_DEPTH_BITS-1:0] new_tag_2;
   logic                              resolve_valid;
   logic [MAX_PREDICT_DEPTH_BITS-1:0] resolve_tag;
   logic                              resolve_mispredict;
   logic                              branch_shootdown;
   logic [MAX_PREDICT_DEPTH_BITS-1:0] shootdown_branch_tag;
   logic [MAX_PREDICT_DEPTH_BITS-1:0] spec_depth;

   modport slave (
      input  req_valid, req_count, req_is_branch, num_free,
             resolve_valid, resolve_tag, resolve_mispredict,
      output req_ready, num_pull, branch_tag_1, branch_tag_2, new_tag_1, new_tag_2,
             branch_shootdown, shootdown_branch_tag, spec_depth
   );

   modport master (
      output req_valid, req_count, req_is_branch, num_free,
             resolve_valid, resolve_tag, resolve_mispredict,
      input  req_ready, num_pull, branch_tag_1, branch_tag_2, new_tag_1, new_tag_2,
             branch_shootdown, shootdown_branch_tag, spec_depth
   );
endinterface

// File: rtl/rename_alloc_ctrl.sv
// Rename allocation controller: gates rename groups on free pregs and branch tags,
// keeps the branch-tag stack, sequences mispredict shootdown. Stall counters under RENAME_STATS_EN.
//
// state | meaning
// RUN   | normal operation, groups may be accepted
// SHOOT | registered shootdown pulse to the freelist
// DRAIN | wait for the freelist's restored num_free
module rename_alloc_ctrl #(
   parameter int NUM_PREGS              = 64,
   parameter int MAX_PREDICT_DEPTH      = 4,
   parameter int MAX_PREDICT_DEPTH_BITS = 3
) (
   input  logic         clk,
   input  logic         reset,
   rename_alloc_if.slave bus
`ifdef RENAME_STATS_EN
   ,
   output logic [31:0]  stall_preg_cnt,
   output logic [31:0]  stall_tag_cnt,
   output logic [31:0]  stall_recover_cnt
`endif
);
   localparam int NFW = $clog2(NUM_PREGS) + 1;
   localparam int DB  = MAX_PREDICT_DEPTH_BITS;

   typedef logic [DB-1:0]  tag_t;
   typedef logic [DB:0]    tagw_t;
   typedef logic [NFW-1:0] nf_t;
   typedef enum logic [1:0] {RUN, SHOOT, DRAIN} state_t;

   state_t                         state;
   tag_t                           depth;
   tag_t                           shoot_tag;
   logic                           shoot;
   logic [MAX_PREDICT_DEPTH:1]     resolved;

   logic                           br0, br1, mp_raw, preg_ok, tag_ok, ready, fire, alloc;
   logic                           res_ok, mp_take;
   tagw_t                          need;
   tag_t                           depth_nx;
   logic [MAX_PREDICT_DEPTH:1]     res_nx;

   always_comb begin
      br0     = (bus.req_count != 2'd0) && bus.req_is_branch[0];
      br1     = (bus.req_count >= 2'd2) && bus.req_is_branch[1];
      mp_raw  = bus.resolve_valid && bus.resolve_mispredict;
      need    = tagw_t'(depth) + tagw_t'(br0) + tagw_t'(br1);
      preg_ok = bus.num_free >= nf_t'(bus.req_count);
      tag_ok  = need <= tagw_t'(MAX_PREDICT_DEPTH);
      ready   = !reset && (state == RUN) && !mp_raw && preg_ok && tag_ok;
      fire    = bus.req_valid && ready;
      alloc   = fire && (br0 || br1);
      // During recovery, tags above the restored depth belong to squashed branches
      res_ok  = bus.resolve_valid && (bus.resolve_tag != '0) &&
                ((state == RUN) || (bus.resolve_tag <= depth));
      mp_take = res_ok && bus.resolve_mispredict;

      res_nx   = resolved;
      depth_nx = depth;
      if (mp_take) begin
         depth_nx = bus.resolve_tag - 1'b1;
         for (int i = 1; i <= MAX_PREDICT_DEPTH; i++)
            if (tag_t'(i) >= bus.resolve_tag) res_nx[i] = 1'b0;
      end else begin
         if (res_ok)
            for (int i = 1; i <= MAX_PREDICT_DEPTH; i++)
               if (bus.resolve_tag == tag_t'(i)) res_nx[i] = 1'b1;
         if (fire) depth_nx = depth + tag_t'(br0) + tag_t'(br1);
         // Pop youngest resolved tags; descending scan makes the cascade single-cycle
         if (!alloc)
            for (int i = MAX_PREDICT_DEPTH; i >= 1; i--)
               if ((depth_nx == tag_t'(i)) && res_nx[i]) begin
                  res_nx[i] = 1'b0;
                  depth_nx  = depth_nx - 1'b1;
               end
      end
   end

   assign bus.req_ready            = ready;
   assign bus.num_pull             = fire ? bus.req_count : 2'd0;
   assign bus.branch_tag_1         = depth;
   assign bus.branch_tag_2         = depth + tag_t'(br0);
   assign bus.new_tag_1            = (fire && br0) ? depth + tag_t'(1) : '0;
   assign bus.new_tag_2            = (fire && br1) ? depth + tag_t'(1) + tag_t'(br0) : '0;
   assign bus.branch_shootdown     = shoot;
   assign bus.shootdown_branch_tag = shoot_tag;
   assign bus.spec_depth           = depth;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         depth     <= '0;
         resolved  <= '0;
         shoot     <= 1'b0;
         shoot_tag <= '0;
      end else begin
         depth     <= depth_nx;
         resolved  <= res_nx;
         shoot     <= mp_take;
         shoot_tag <= mp_take ? bus.resolve_tag : '0;
         case (state)
            RUN:     state <= mp_take ? SHOOT : RUN;
            SHOOT:   state <= mp_take ? SHOOT : DRAIN;
            DRAIN:   state <= mp_take ? SHOOT : RUN;
            default: state <= RUN;
         endcase
      end
   end

`ifdef RENAME_STATS_EN
   logic run_idle;
   assign run_idle = (state == RUN) && !mp_raw && bus.req_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_preg_cnt    <= '0;
         stall_tag_cnt     <= '0;
         stall_recover_cnt <= '0;
      end else begin
         if (run_idle && !preg_ok && (stall_preg_cnt != '1))
            stall_preg_cnt <= stall_preg_cnt + 32'd1;
         if (run_idle && !tag_ok && (stall_tag_cnt != '1))
            stall_tag_cnt <= stall_tag_cnt + 32'd1;
         if (((state != RUN) || mp_raw) && (stall_recover_cnt != '1))
            stall_recover_cnt <= stall_recover_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed bench for rename_alloc_ctrl: tag stack, pops, recovery sequencing, preg stalls.
module tb_rename_alloc_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   rename_alloc_if #(.NUM_PREGS(64), .MAX_PREDICT_DEPTH_BITS(3)) bif ();

   rename_alloc_ctrl #(.NUM_PREGS(64), .MAX_PREDICT_DEPTH(4), .MAX_PREDICT_DEPTH_BITS(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic [1:0] c, input logic [1:0] b);
      bif.req_valid     = v;
      bif.req_count     = c;
      bif.req_is_branch = b;
   endtask

   task automatic set_res(input logic v, input logic [2:0] t, input logic m);
      bif.resolve_valid      = v;
      bif.resolve_tag        = t;
      bif.resolve_mispredict = m;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_req(1'b1, 2'd2, 2'b00);
      set_res(1'b0, 3'd0, 1'b0);
      bif.num_free = 7'd64;
      tick(); tick();
      total++; if (bif.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", bif.req_ready); end
      total++; if (bif.num_pull !== 2'd0) begin bad++; $display("FAIL rst_pull got=%0d exp=0", bif.num_pull); end
      reset = 1'b0;
      set_req(1'b0, 2'd0, 2'b00);
      tick();
      total++; if (bif.spec_depth !== 3'd0) begin bad++; $display("FAIL rst_depth got=%0d exp=0", bif.spec_depth); end
      total++; if (bif.branch_shootdown !== 1'b0) begin bad++; $display("FAIL rst_shoot got=%0b exp=0", bif.branch_shootdown); end
      total++; if (bif.shootdown_branch_tag !== 3'd0) begin bad++; $display("FAIL rst_shoot_tag got=%0d exp=0", bif.shootdown_branch_tag); end
   endtask

   task automatic test_no_branch();
      set_req(1'b1, 2'd2, 2'b00);
      #1;
      total++; if (bif.req_ready !== 1'b1) begin bad++; $display("FAIL nb_ready got=%0b exp=1", bif.req_ready); end
      total++; if (bif.num_pull !== 2'd2) begin bad++; $display("FAIL nb_pull got=%0d exp=2", bif.num_pull); end
      total++; if (bif.branch_tag_1 !== 3'd0 || bif.branch_tag_2 !== 3'd0)
         begin bad++; $display("FAIL nb_btags got=%0d,%0d exp=0,0", bif.branch_tag_1, bif.branch_tag_2); end
      tick();
      total++; if (bif.spec_depth !== 3'd0) begin bad++; $display("FAIL nb_depth got=%0d exp=0", bif.spec_depth); end
   endtask

   task automatic test_branch_alloc();
      set_req(1'b1, 2'd2, 2'b01);
      #1;
      total++; if (bif.new_tag_1 !== 3'd1 || bif.new_tag_2 !== 3'd0)
         begin bad++; $display("FAIL ba1_new got=%0d,%0d exp=1,0", bif.new_tag_1, bif.new_tag_2); end
      total++; if (bif.branch_tag_1 !== 3'd0 || bif.branch_tag_2 !== 3'd1)
         begin bad++; $display("FAIL ba1_btags got=%0d,%0d exp=0,1", bif.branch_tag_1, bif.branch_tag_2); end
      tick();
      total++; if (bif.spec_depth !== 3'd1) begin bad++; $display("FAIL ba1_depth got=%0d exp=1", bif.spec_depth); end
      set_req(1'b1, 2'd2, 2'b11);
      #1;
      total++; if (bif.new_tag_1 !== 3'd2 || bif.new_tag_2 !== 3'd3)
         begin bad++; $display("FAIL ba2_new got=%0d,%0d exp=2,3", bif.new_tag_1, bif.new_tag_2); end
      total++; if (bif.branch_tag_1 !== 3'd1 || bif.branch_tag_2 !== 3'd2)
         begin bad++; $display("FAIL ba2_btags got=%0d,%0d exp=1,2", bif.branch_tag_1, bif.branch_tag_2); end
      tick();
      total++; if (bif.spec_depth !== 3'd3) begin bad++; $display("FAIL ba2_depth got=%0d exp=3", bif.spec_depth); end
      set_req(1'b1, 2'd1, 2'b01);
      #1;
      total++; if (bif.new_tag_1 !== 3'd4) begin bad++; $display("FAIL ba3_new got=%0d exp=4", bif.new_tag_1); end
      tick();
      total++; if (bif.spec_depth !== 3'd4) begin bad++; $display("FAIL ba3_depth got=%0d exp=4", bif.spec_depth); end
   endtask

   task automatic test_tag_exhaust();
      set_req(1'b1, 2'd1, 2'b01);
      set_res(1'b1, 3'd4, 1'b0);
      #1;
      total++; if (bif.req_ready !== 1'b0) begin bad++; $display("FAIL ex_ready got=%0b exp=0", bif.req_ready); end
      total++; if (bif.num_pull !== 2'd0) begin bad++; $display("FAIL ex_pull got=%0d exp=0", bif.num_pull); end
      tick();
      set_res(1'b0, 3'd0, 1'b0);
      total++; if (bif.spec_depth !== 3'd3) begin bad++; $display("FAIL ex_pop_depth got=%0d exp=3", bif.spec_depth); end
      #1;
      total++; if (bif.req_ready !== 1'b1 || bif.new_tag_1 !== 3'd4)
         begin bad++; $display("FAIL ex_retry got=%0b,%0d exp=1,4", bif.req_ready, bif.new_tag_1); end
      tick();
      set_req(1'b0, 2'd1, 2'b01);
      set_res(1'b1, 3'd4, 1'b0);
      tick();
      set_res(1'b0, 3'd0, 1'b0);
      total++; if (bif.spec_depth !== 3'd3) begin bad++; $display("FAIL ex_depth3 got=%0d exp=3", bif.spec_depth); end
   endtask

   task automatic test_cascade();
      set_req(1'b0, 2'd0, 2'b00);
      set_res(1'b1, 3'd2, 1'b0);
      tick();
      total++; if (bif.spec_depth !== 3'd3) begin bad++; $display("FAIL cas_hold got=%0d exp=3", bif.spec_depth); end
      set_res(1'b1, 3'd3, 1'b0);
      tick();
      set_res(1'b0, 3'd0, 1'b0);
      total++; if (bif.spec_depth !== 3'd1) begin bad++; $display("FAIL cas_pop got=%0d exp=1", bif.spec_depth); end
   endtask

   task automatic test_mispredict();
      set_req(1'b1, 2'd2, 2'b11);
      tick();
      total++; if (bif.spec_depth !== 3'd3) begin bad++; $display("FAIL mp_setup got=%0d exp=3", bif.spec_depth); end
      set_req(1'b1, 2'd0, 2'b00);
      set_res(1'b1, 3'd2, 1'b1);
      #1;
      total++; if (bif.req_ready !== 1'b0) begin bad++; $display("FAIL mp_ready0 got=%0b exp=0", bif.req_ready); end
      tick();
      set_res(1'b0, 3'd0, 1'b0);
      #1;
      total++; if (bif.branch_shootdown !== 1'b1 || bif.shootdown_branch_tag !== 3'd2)
         begin bad++; $display("FAIL mp_shoot got=%0b,%0d exp=1,2", bif.branch_shootdown, bif.shootdown_branch_tag); end
      total++; if (bif.spec_depth !== 3'd1) begin bad++; $display("FAIL mp_depth got=%0d exp=1", bif.spec_depth); end
      total++; if (bif.req_ready !== 1'b0) begin bad++; $display("FAIL mp_ready1 got=%0b exp=0", bif.req_ready); end
      tick();
      total++; if (bif.branch_shootdown !== 1'b0) begin bad++; $display("FAIL mp_pulse got=%0b exp=0", bif.branch_shootdown); end
      total++; if (bif.req_ready !== 1'b0) begin bad++; $display("FAIL mp_ready2 got=%0b exp=0", bif.req_ready); end
      tick();
      total++; if (bif.req_ready !== 1'b1) begin bad++; $display("FAIL mp_ready3 got=%0b exp=1", bif.req_ready); end
   endtask

   task automatic test_preg_stall();
      bif.num_free = 7'd1;
      set_req(1'b1, 2'd2, 2'b00);
      #1;
      total++; if (bif.req_ready !== 1'b0 || bif.num_pull !== 2'd0)
         begin bad++; $display("FAIL pr_stall got=%0b,%0d exp=0,0", bif.req_ready, bif.num_pull); end
      tick();
      bif.num_free = 7'd2;
      #1;
      total++; if (bif.req_ready !== 1'b1 || bif.num_pull !== 2'd2)
         begin bad++; $display("FAIL pr_go got=%0b,%0d exp=1,2", bif.req_ready, bif.num_pull); end
      bif.num_free = 7'd0;
      set_req(1'b1, 2'd0, 2'b00);
      #1;
      total++; if (bif.req_ready !== 1'b1) begin bad++; $display("FAIL pr_zero got=%0b exp=1", bif.req_ready); end
      tick();
      bif.num_free = 7'd64;
      total++; if (bif.spec_depth !== 3'd1) begin bad++; $display("FAIL pr_depth got=%0d exp=1", bif.spec_depth); end
   endtask

   task automatic test_restart();
      set_req(1'b1, 2'd2, 2'b11);
      tick();
      set_req(1'b0, 2'd0, 2'b00);
      set_res(1'b1, 3'd3, 1'b1);
      tick();
      total++; if (bif.branch_shootdown !== 1'b1 || bif.shootdown_branch_tag !== 3'd3 || bif.spec_depth !== 3'd2)
         begin bad++; $display("FAIL rs_first got=%0b,%0d,%0d exp=1,3,2", bif.branch_shootdown, bif.shootdown_branch_tag, bif.spec_depth); end
      tick();
      total++; if (bif.branch_shootdown !== 1'b0 || bif.spec_depth !== 3'd2)
         begin bad++; $display("FAIL rs_ignore got=%0b,%0d exp=0,2", bif.branch_shootdown, bif.spec_depth); end
      set_res(1'b1, 3'd1, 1'b1);
      tick();
      set_res(1'b0, 3'd0, 1'b0);
      total++; if (bif.branch_shootdown !== 1'b1 || bif.shootdown_branch_tag !== 3'd1 || bif.spec_depth !== 3'd0)
         begin bad++; $display("FAIL rs_restart got=%0b,%0d,%0d exp=1,1,0", bif.branch_shootdown, bif.shootdown_branch_tag, bif.spec_depth); end
      tick();
      total++; if (bif.req_ready !== 1'b0) begin bad++; $display("FAIL rs_drain got=%0b exp=0", bif.req_ready); end
      tick();
      total++; if (bif.req_ready !== 1'b1) begin bad++; $display("FAIL rs_run got=%0b exp=1", bif.req_ready); end
   endtask

   task automatic test_reset_mid();
      set_req(1'b1, 2'd2, 2'b11);
      tick();
      set_req(1'b0, 2'd0, 2'b00);
      set_res(1'b1, 3'd2, 1'b1);
      tick();
      set_res(1'b0, 3'd0, 1'b0);
      total++; if (bif.branch_shootdown !== 1'b1 || bif.spec_depth !== 3'd1)
         begin bad++; $display("FAIL rm_shoot got=%0b,%0d exp=1,1", bif.branch_shootdown, bif.spec_depth); end
      reset = 1'b1;
      tick();
      total++; if (bif.branch_shootdown !== 1'b0 || bif.spec_depth !== 3'd0 || bif.req_ready !== 1'b0)
         begin bad++; $display("FAIL rm_reset got=%0b,%0d,%0b exp=0,0,0", bif.branch_shootdown, bif.spec_depth, bif.req_ready); end
      reset = 1'b0;
      set_req(1'b1, 2'd1, 2'b01);
      #1;
      total++; if (bif.req_ready !== 1'b1 || bif.new_tag_1 !== 3'd1)
         begin bad++; $display("FAIL rm_run got=%0b,%0d exp=1,1", bif.req_ready, bif.new_tag_1); end
      tick();
      set_req(1'b0, 2'd0, 2'b00);
      total++; if (bif.branch_shootdown !== 1'b0 || bif.spec_depth !== 3'd1)
         begin bad++; $display("FAIL rm_after got=%0b,%0d exp=0,1", bif.branch_shootdown, bif.spec_depth); end
   endtask

   initial begin
      test_reset();
      test_no_branch();
      test_branch_alloc();
      test_tag_exhaust();
      test_cascade();
      test_mispredict();
      test_preg_stall();
      test_restart();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
